// File: rtl/game_pkg.sv
// Shared game-level constants: state codes and layer indices
// used by the VGA pixel path.
package game_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        TITLE    = 4'd0,
        STAFF    = 4'd1,
        STAGE1   = 4'd2,
        SUCCESS1 = 4'd3,
        STAGE2   = 4'd4,
        SUCCESS2 = 4'd5,
        STAGE3   = 4'd6,
        SUCCESS3 = 4'd7,
        FAIL     = 4'd8
    } game_state_e;

    typedef enum logic [2:0] {
        INTERFACE = 3'd0,
        OBJ       = 3'd1,
        MAP       = 3'd2,
        DOOR      = 3'd3,
        BOSS      = 3'd4,
        PLAYER    = 3'd5
    } layer_e;

endpackage

// File: rtl/prio_encoder.sv
// Lowest-set-bit priority encoder with a valid flag.
// Bit 0 has the highest priority.
module prio_encoder #(
    parameter int WIDTH = 6,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan downwards so the lowest set bit is written last.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: per-state visibility mask, priority
// select and frame-counted blanking after game-state changes.
module layer_compositor #(
    parameter int NUM_LAYERS   = 6,
    parameter int ADDR_W       = 17,
    parameter int STATE_W      = game_pkg::STATE_W,
    parameter int NUM_STATES   = 9,
    parameter int TRANS_FRAMES = 2,
    parameter logic [NUM_LAYERS-1:0] MASK_RESET = '1,
    localparam int LAYER_W =
        (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int CNT_W =
        (TRANS_FRAMES > 0) ? $clog2(TRANS_FRAMES + 1) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [STATE_W-1:0]           state,
    input  logic [9:0]                   h_cnt,
    input  logic [9:0]                   v_cnt,
    input  logic [NUM_LAYERS-1:0]        layer_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic                         cfg_we,
    input  logic [STATE_W-1:0]           cfg_state,
    input  logic [NUM_LAYERS-1:0]        cfg_mask,
    output logic [ADDR_W-1:0]            pixel_addr,
    output logic [LAYER_W-1:0]           pixel_layer,
    output logic                         notBlank
);

    import game_pkg::*;

    logic [NUM_LAYERS-1:0] mask [NUM_STATES];
    logic [STATE_W-1:0]    prev_state;
    logic [CNT_W-1:0]      trans_cnt;
    logic [CNT_W-1:0]      trans_next;

    logic state_ok;
    logic cfg_ok;
    logic frame_start;
    logic change;
    logic [NUM_LAYERS-1:0] eff_hit;

    logic [NUM_LAYERS-1:0] s1_hit;
    logic [ADDR_W-1:0]     s1_addr [NUM_LAYERS];
    logic                  s1_blank;

    logic [LAYER_W-1:0] enc_idx;
    logic               enc_valid;

    assign state_ok    = int'(state) < NUM_STATES;
    assign cfg_ok      = int'(cfg_state) < NUM_STATES;
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign change      = state != prev_state;
    assign eff_hit     = state_ok ? (layer_hit & mask[state]) : '0;

    // Reload beats decrement when a change lands on a frame start.
    always_comb begin
        trans_next = trans_cnt;
        if (change) begin
            trans_next = CNT_W'(TRANS_FRAMES);
        end else if (frame_start && trans_cnt != '0) begin
            trans_next = trans_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                mask[i] <= MASK_RESET;
            end
        end else if (cfg_we && cfg_ok) begin
            mask[cfg_state] <= cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= '0;
            trans_cnt  <= '0;
        end else begin
            prev_state <= state;
            trans_cnt  <= trans_next;
        end
    end

    // Blank flag uses the post-update count, so the pixel on the
    // change cycle is blanked and the final frame-start pixel is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hit   <= '0;
            s1_blank <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                s1_addr[i] <= '0;
            end
        end else begin
            s1_hit   <= eff_hit;
            s1_blank <= trans_next != '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                s1_addr[i] <= layer_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    prio_encoder #(
        .WIDTH (NUM_LAYERS),
        .IDX_W (LAYER_W)
    ) u_prio (
        .req   (s1_hit),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr  <= '0;
            pixel_layer <= '0;
            notBlank    <= 1'b0;
        end else if (enc_valid && !s1_blank) begin
            pixel_addr  <= s1_addr[enc_idx];
            pixel_layer <= enc_idx;
            notBlank    <= 1'b1;
        end else begin
            pixel_addr  <= '0;
            pixel_layer <= '0;
            notBlank    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized bench for layer_compositor against a frame-counting
// reference model, plus directed boundary scenarios.
module tb_layer_compositor;

    localparam int NL = 6;
    localparam int AW = 17;
    localparam int SW = 4;
    localparam int NS = 9;
    localparam int TF = 2;
    localparam int HW = 20;
    localparam int VH = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] state;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [NL-1:0] layer_hit;
    logic [NL*AW-1:0] layer_addr;
    logic          cfg_we;
    logic [SW-1:0] cfg_state;
    logic [NL-1:0] cfg_mask;
    logic [AW-1:0] pixel_addr;
    logic [2:0]    pixel_layer;
    logic          notBlank;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS   (NL),
        .ADDR_W       (AW),
        .STATE_W      (SW),
        .NUM_STATES   (NS),
        .TRANS_FRAMES (TF),
        .MASK_RESET   ({NL{1'b1}})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .layer_hit   (layer_hit),
        .layer_addr  (layer_addr),
        .cfg_we      (cfg_we),
        .cfg_state   (cfg_state),
        .cfg_mask    (cfg_mask),
        .pixel_addr  (pixel_addr),
        .pixel_layer (pixel_layer),
        .notBlank    (notBlank)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] want
    );
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Reference model: frames seen since the last state change.
    logic [NL-1:0] m_mask [NS];
    logic [SW-1:0] m_prev;
    int            since;
    logic [31:0]   pend;

    function automatic logic [31:0] outword();
        return {11'b0, notBlank, pixel_layer, pixel_addr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_mask[i] = '1;
        m_prev = '0;
        since  = TF;
        pend   = '0;
    endtask

    task automatic set_addr(input int i, input int val);
        layer_addr[i*AW +: AW] = AW'(val);
    endtask

    task automatic cycle();
        logic [31:0]   nxt;
        logic [NL-1:0] eff;
        logic          fs;
        logic          blanked;
        int            k;
        @(posedge clk);
        fs = (h_cnt == 0) && (v_cnt == 0);
        if (state != m_prev) since = 0;
        else if (fs && since < 1000) since++;
        m_prev  = state;
        blanked = since < TF;
        eff = (int'(state) < NS) ? (layer_hit & m_mask[state]) : '0;
        k = -1;
        for (int i = 0; i < NL; i++) begin
            if (k < 0 && eff[i]) k = i;
        end
        if (k < 0 || blanked) nxt = '0;
        else nxt = {11'b0, 1'b1, 3'(k), layer_addr[k*AW +: AW]};
        if (cfg_we && int'(cfg_state) < NS) m_mask[cfg_state] = cfg_mask;
        #1;
        check("pix", outword(), pend);
        pend = nxt;
        if (h_cnt == 10'(HW - 1)) begin
            h_cnt = '0;
            v_cnt = (v_cnt == 10'(VH - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt = h_cnt + 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic to_frame_start();
        int guard = 0;
        while (!(h_cnt == 0 && v_cnt == 0) && guard < 200) begin
            cycle();
            guard++;
        end
    endtask

    initial begin
        int c;
        rst        = 1'b1;
        state      = '0;
        h_cnt      = 10'd5;
        v_cnt      = '0;
        layer_hit  = 6'b010100;
        layer_addr = '0;
        set_addr(2, 100);
        set_addr(4, 200);
        cfg_we     = 1'b0;
        cfg_state  = '0;
        cfg_mask   = '0;
        model_reset();
        #23;
        check("rst_out", outword(), 0);
        @(negedge clk);
        rst = 1'b0;

        run(2);
        check("tp1_addr", pixel_addr, 100);
        check("tp1_layer", pixel_layer, 2);
        check("tp1_nb", notBlank, 1);

        state = 4'd2;
        run(250);
        cfg_we    = 1'b1;
        cfg_state = 4'd2;
        cfg_mask  = 6'b111011;
        cycle();
        cfg_we = 1'b0;
        cycle();
        check("tp2_old", pixel_addr, 100);
        cycle();
        check("tp2_new", pixel_addr, 200);
        check("tp2_layer", pixel_layer, 4);

        layer_hit = '0;
        run(2);
        check("tp3_nohit", notBlank, 0);
        layer_hit = 6'b010100;
        state     = 4'd12;
        cfg_we    = 1'b1;
        cfg_state = 4'd12;
        cfg_mask  = '0;
        run(3);
        cfg_we = 1'b0;
        check("tp3_badstate", outword(), 0);

        state = 4'd0;
        run(250);
        run(37);
        state = 4'd2;
        run(5);
        check("tp4_blank", notBlank, 0);
        to_frame_start();
        run(10);
        state = 4'd4;
        run(3);
        check("tp5_restart", notBlank, 0);
        to_frame_start();
        state = 4'd6;
        cycle();
        c = 0;
        while (c < 400) begin
            cycle();
            c++;
            if (notBlank) break;
        end
        check("tp5_coincident_len", c, 201);

        cfg_we    = 1'b1;
        cfg_state = 4'd0;
        cfg_mask  = 6'b111011;
        cycle();
        cfg_we = 1'b0;
        run(7);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid", outword(), 0);
        state = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle();
        check("rst_first", outword(), 0);
        cycle();
        check("rst_mask", pixel_addr, 100);

        for (int n = 0; n < 3000; n++) begin
            layer_hit = NL'($urandom);
            for (int i = 0; i < NL; i++) set_addr(i, int'($urandom));
            cfg_we    = ($urandom % 12) == 0;
            cfg_state = SW'($urandom % 12);
            cfg_mask  = NL'($urandom);
            if ($urandom % 150 == 0) state = SW'($urandom % 10);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
